// File: rtl/router_pkg.sv
// router_pkg
//   Shared constants for the router datapath.
//   DATA_W       : byte width of the packet datapath.
//   ADDR_W       : width of the destination address field in the header.
//   ADDR_INVALID : address code that has no output port and is never latched.
package router_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_parity_chk.sv
// router_parity_chk
//   Running XOR parity of a packet, the received parity byte and the error flag.
//   Ports:
//     clock, resetn  : clock, asynchronous active-low reset
//     clr            : start of a new packet (decode-address)
//     hdr_load       : fold header_byte into the running parity
//     data_accum     : fold data_in into the running parity
//     pp_load        : capture data_in as the received parity byte
//     parity_done    : parity byte is in hand, err may be evaluated
//     header_byte    : latched header byte
//     data_in        : incoming packet byte
//     err            : running parity differs from received parity
module router_parity_chk
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              clr,
    input  logic              hdr_load,
    input  logic              data_accum,
    input  logic              pp_load,
    input  logic              parity_done,
    input  logic [DATA_W-1:0] header_byte,
    input  logic [DATA_W-1:0] data_in,
    output logic              err
);

    logic [DATA_W-1:0] internal_parity;
    logic [DATA_W-1:0] packet_parity;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            internal_parity <= '0;
        end else if (clr) begin
            internal_parity <= '0;
        end else if (hdr_load) begin
            internal_parity <= internal_parity ^ header_byte;
        end else if (data_accum) begin
            internal_parity <= internal_parity ^ data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            packet_parity <= '0;
        end else if (clr) begin
            packet_parity <= '0;
        end else if (pp_load) begin
            packet_parity <= data_in;
        end
    end

    // err follows the comparison while parity_done is high, so it settles
    // one cycle after parity_done rises and then holds until the next packet.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (clr) begin
            err <= 1'b0;
        end else if (parity_done) begin
            err <= (internal_parity != packet_parity);
        end
    end

endmodule

// File: rtl/router_reg.sv
// router_reg
//   Datapath register stage of the 1x3 router. Latches the header, forwards
//   header/payload/parity bytes on dout, parks the byte that arrives while the
//   target FIFO is full and replays it afterwards, and reports parity status.
//   Ports:
//     clock, resetn     : clock, asynchronous active-low reset
//     pkt_valid         : high for header/payload bytes, low for the parity byte
//     data_in           : packet byte, header bits [1:0] = destination address
//     fifo_full         : selected output FIFO is full
//     detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg
//                       : one-hot state strobes from the router control FSM
//     parity_done       : parity byte has been captured and forwarded
//     low_packet_valid  : pkt_valid fell during load-data
//     err               : parity mismatch for the completed packet
//     dout              : byte presented to the FIFO write port
//
//   Handshake: there is no valid/ready pair on this block. A byte on data_in
//   is consumed in the cycle the FSM strobe names it (lfd/ld/laf); fifo_full
//   acts as the not-ready and diverts the byte into the full-byte register.
//   dout is updated exactly one cycle after each consuming strobe and holds
//   otherwise.
module router_reg
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic              parity_done,
    output logic              low_packet_valid,
    output logic              err,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] header_reg;
    logic [DATA_W-1:0] full_reg;

    // Strobes are one-hot, but decode with fixed priority so an illegal
    // overlap still resolves deterministically.
    logic do_detect;
    logic do_lfd;
    logic do_ld;
    logic do_laf;

    assign do_detect = detect_add;
    assign do_lfd    = lfd_state & ~detect_add;
    assign do_ld     = ld_state  & ~detect_add & ~lfd_state;
    assign do_laf    = laf_state & ~detect_add & ~lfd_state & ~ld_state;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header_reg <= '0;
        end else if (do_detect && pkt_valid && (data_in[ADDR_W-1:0] != ADDR_INVALID)) begin
            header_reg <= data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout     <= '0;
            full_reg <= '0;
        end else if (do_lfd) begin
            dout <= header_reg;
        end else if (do_ld) begin
            if (fifo_full) begin
                full_reg <= data_in;
            end else begin
                dout <= data_in;
            end
        end else if (do_laf) begin
            dout <= full_reg;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            low_packet_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_packet_valid <= 1'b0;
        end else if (do_ld && !pkt_valid) begin
            low_packet_valid <= 1'b1;
        end
    end

    // A parity byte that met a full FIFO only counts as done once it has
    // been replayed from the full-byte register in load-after-full.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_done <= 1'b0;
        end else if (do_detect) begin
            parity_done <= 1'b0;
        end else if ((do_ld && !fifo_full && !pkt_valid) ||
                     (do_laf && low_packet_valid && !parity_done)) begin
            parity_done <= 1'b1;
        end
    end

    // A diverted payload byte is accumulated in its load-data cycle; the
    // later replay is deliberately not folded in a second time.
    router_parity_chk u_parity_chk (
        .clock       (clock),
        .resetn      (resetn),
        .clr         (do_detect),
        .hdr_load    (do_lfd),
        .data_accum  (do_ld && pkt_valid && !full_state),
        .pp_load     (do_ld && !pkt_valid),
        .parity_done (parity_done),
        .header_byte (header_reg),
        .data_in     (data_in),
        .err         (err)
    );

endmodule

// File: tb/tb_router_reg.sv
module tb_router_reg;

    localparam int W = 8;

    // Cycle annotations written by the driver, consumed by the monitor one
    // clock edge later.
    localparam int K_IDLE   = 0;  // no byte delivered, dout must hold
    localparam int K_DELIV  = 1;  // header/payload byte delivered
    localparam int K_PAR    = 2;  // parity byte delivered
    localparam int K_DEFER  = 3;  // parity byte hit a full FIFO
    localparam int K_CHECK  = 4;  // check-parity cycle
    localparam int K_DETECT = 5;  // decode-address cycle
    localparam int K_POST   = 6;  // idle after check, err must hold

    // ---------------- clock / reset ----------------
    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         pkt_valid = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         fifo_full = 1'b0;
    logic         detect_add = 1'b0;
    logic         lfd_state = 1'b0;
    logic         ld_state = 1'b0;
    logic         laf_state = 1'b0;
    logic         full_state = 1'b0;
    logic         rst_int_reg = 1'b0;
    logic         parity_done;
    logic         low_packet_valid;
    logic         err;
    logic [W-1:0] dout;

    always #5 clock = ~clock;

    router_reg dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err),
        .dout             (dout)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: bench still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic         exp_err_q[$];
    logic [W-1:0] pl[$];
    logic [W-1:0] last_hdr = '0;
    logic [W-1:0] last_dout = '0;
    logic         last_err = 1'b0;
    int           kind_now = K_IDLE;
    int           kind_d;
    int           checks = 0;
    int           passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clock or negedge resetn) begin
        if (!resetn) kind_d <= K_IDLE;
        else         kind_d <= kind_now;
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin : monitor
        logic [W-1:0] e;
        if (resetn) begin
            if (kind_d == K_DELIV || kind_d == K_PAR) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL dout_unexpected: got %0h expected no delivery", dout);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", dout, e);
                    last_dout = e;
                end
            end else begin
                check("dout_hold", dout, last_dout);
            end
            case (kind_d)
                K_DELIV: begin
                    check("parity_done_low", parity_done, 1'b0);
                    check("lpv_low", low_packet_valid, 1'b0);
                end
                K_PAR: begin
                    check("parity_done_rise", parity_done, 1'b1);
                    check("lpv_set", low_packet_valid, 1'b1);
                end
                K_DEFER: begin
                    check("parity_done_deferred", parity_done, 1'b0);
                    check("lpv_deferred", low_packet_valid, 1'b1);
                end
                K_CHECK: begin
                    check("parity_done_held", parity_done, 1'b1);
                    check("lpv_cleared", low_packet_valid, 1'b0);
                    if (exp_err_q.size() == 0) begin
                        checks++;
                        $display("FAIL err_unexpected: got %0b expected no check", err);
                    end else begin
                        last_err = exp_err_q.pop_front();
                        check("err", err, last_err);
                    end
                end
                K_POST:   check("err_hold", err, last_err);
                K_DETECT: begin
                    check("err_clr", err, 1'b0);
                    check("parity_done_clr", parity_done, 1'b0);
                end
                default: ;
            endcase
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic da, input logic lf, input logic ld, input logic la,
                       input logic fs, input logic ri, input logic pv, input logic ff,
                       input logic [W-1:0] d, input int k);
        @(negedge clock);
        detect_add = da; lfd_state = lf; ld_state = ld; laf_state = la;
        full_state = fs; rst_int_reg = ri; pkt_valid = pv; fifo_full = ff;
        data_in = d; kind_now = k;
        @(posedge clock);
    endtask

    // Sends hdr + pl[] + parity. Parity byte is the XOR of the header that
    // will actually be forwarded and the payload, XORed with delta.
    // full_idx selects one byte (pl.size() = parity byte) that meets a full
    // FIFO; full_pct adds random stalls on top.
    task automatic send_packet(input logic [W-1:0] hdr, input logic [W-1:0] delta,
                               input int full_idx, input int full_pct);
        logic [W-1:0] eh, x, par, b;
        bit is_par, full;
        int n;
        n  = pl.size();
        eh = (hdr[1:0] != 2'b11) ? hdr : last_hdr;
        last_hdr = eh;
        x = eh;
        foreach (pl[i]) x ^= pl[i];
        par = x ^ delta;
        exp_err_q.push_back(delta != '0);

        cyc(1, 0, 0, 0, 0, 0, 1, 0, hdr, K_DETECT);
        exp_q.push_back(eh);
        cyc(0, 1, 0, 0, 0, 0, 1, 0, W'($urandom), K_DELIV);
        for (int i = 0; i <= n; i++) begin
            is_par = (i == n);
            b = is_par ? par : pl[i];
            full = (i == full_idx) || ($urandom_range(0, 99) < full_pct);
            if (!full) begin
                exp_q.push_back(b);
                cyc(0, 0, 1, 0, 0, 0, !is_par, 0, b, is_par ? K_PAR : K_DELIV);
            end else begin
                cyc(0, 0, 1, 0, 0, 0, !is_par, 1, b, is_par ? K_DEFER : K_IDLE);
                repeat ($urandom_range(0, 2))
                    cyc(0, 0, 0, 0, 1, 0, !is_par, 1, W'($urandom), K_IDLE);
                exp_q.push_back(b);
                cyc(0, 0, 0, 1, 0, 0, !is_par, 0, W'($urandom), is_par ? K_PAR : K_DELIV);
            end
        end
        cyc(0, 0, 0, 0, 0, 1, 0, 0, W'($urandom), K_CHECK);
        repeat ($urandom_range(1, 2))
            cyc(0, 0, 0, 0, 0, 0, 0, 0, W'($urandom), K_POST);
    endtask

    initial begin
        // Reset at start.
        #12;
        check("rst_dout", dout, '0);
        check("rst_err", err, 1'b0);
        check("rst_parity_done", parity_done, 1'b0);
        check("rst_lpv", low_packet_valid, 1'b0);
        @(posedge clock); #1 resetn = 1'b1;

        // Good packet: 0D ^ 11 ^ 22 ^ 33 = 0D, so delta 0 gives parity 8'h0D.
        pl = '{8'h11, 8'h22, 8'h33};
        send_packet(8'h0D, 8'h00, -1, 0);
        // Same packet with parity 8'h3C (= 8'h0D ^ 8'h31).
        send_packet(8'h0D, 8'h31, -1, 0);
        // Payload A5 stalls on a full FIFO, replayed after load-after-full.
        pl = '{8'h11, 8'hA5, 8'h22};
        send_packet(8'h0D, 8'h00, 1, 0);
        // Parity byte meets a full FIFO.
        pl = '{8'h44, 8'h55};
        send_packet(8'h0D, 8'h00, 2, 0);
        // Address 3: header register keeps 8'h0D, parity folds 8'h0D in.
        pl = '{8'h01, 8'h02};
        send_packet(8'h07, 8'h00, -1, 0);

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            int n;
            logic [W-1:0] d;
            n = $urandom_range(1, 8);
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(W'($urandom));
            d = ($urandom_range(0, 99) < 30) ? W'($urandom_range(1, 255)) : '0;
            send_packet(W'($urandom), d, -1, 25);
        end

        // Reset while a parity byte is parked in the full-byte register.
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 8'h4A, K_DETECT);
        last_hdr = 8'h4A;
        exp_q.push_back(8'h4A);
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 8'h00, K_DELIV);
        exp_q.push_back(8'h5B);
        cyc(0, 0, 1, 0, 0, 0, 1, 0, 8'h5B, K_DELIV);
        cyc(0, 0, 1, 0, 0, 0, 0, 1, 8'h11, K_DEFER);
        @(negedge clock);
        detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
        full_state = 0; rst_int_reg = 0; pkt_valid = 0; fifo_full = 0;
        kind_now = K_IDLE;
        #2 resetn = 1'b0;
        #1;
        check("midrst_dout", dout, '0);
        check("midrst_err", err, 1'b0);
        check("midrst_parity_done", parity_done, 1'b0);
        check("midrst_lpv", low_packet_valid, 1'b0);
        exp_q.delete();
        exp_err_q.delete();
        last_dout = '0;
        last_hdr = '0;
        @(posedge clock); #1 resetn = 1'b1;

        // Fresh packet after the reset starts from a clean header.
        pl = '{8'h9C, 8'h3E};
        send_packet(8'h02, 8'h00, -1, 0);
        // Invalid address right after reset falls back to the 8'h02 header.
        pl = '{8'h10};
        send_packet(8'hFF, 8'h00, 1, 0);

        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, '0, K_IDLE);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp_err_q_drained", exp_err_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
